// File: rtl/hub75_bram_scan.sv
// HUB75 scan engine: streams frame BRAM words row-pair by row-pair into the panel,
// latches each row and lights it for ON_CYCLES. Define HUB75_BANK_EN for the bank_sel frame-bank input.
module hub75_bram_scan #(
    parameter int          COLS      = 64,
    parameter int          ROWS      = 16,
    parameter int          ROW_BITS  = 4,
    parameter logic [15:0] ON_CYCLES = 16'd256
) (
    input  logic                HUB_clk,
    input  logic                HUB_rst,
    output logic [7:0]          BRAM_addr,
    output logic                BRAM_en,
    input  logic [63:0]         BRAM_data,
    output logic                PNL_r1,
    output logic                PNL_g1,
    output logic                PNL_b1,
    output logic                PNL_r2,
    output logic                PNL_g2,
    output logic                PNL_b2,
    output logic                PNL_sclk,
    output logic                PNL_lat,
    output logic                PNL_oe_n,
    output logic [ROW_BITS-1:0] PNL_addr,
    output logic                FRM_done
`ifdef HUB75_BANK_EN
    ,
    input  logic                bank_sel
`endif
);

    localparam int WPR       = COLS / 8;
    localparam int WORD_BITS = (WPR > 1) ? $clog2(WPR) : 1;
    localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(WPR - 1);
    localparam logic [ROW_BITS-1:0]  LAST_ROW  = ROW_BITS'(ROWS - 1);
    localparam logic [7:0]           WPR_8     = 8'(WPR);

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4,
        ST_DISPLAY  = 3'd5
    } state_t;

    state_t               state_r;
    logic [ROW_BITS-1:0]  row_r;
    logic [WORD_BITS-1:0] word_r;
    logic [2:0]           col_r;
    logic [47:0]          shift_r;
    logic [15:0]          on_cnt_r;
    logic [7:0]           lin_addr_s;
    logic [7:0]           fetch_addr_s;
    logic [47:0]          shift_src_s;
    logic                 unused_data_s;
`ifdef HUB75_BANK_EN
    logic                 bank_r;
    logic                 bank_next_s;
`endif

    // Word address and the BRAM address presented on FETCH
    always_comb begin
        lin_addr_s = 8'(row_r) * WPR_8 + 8'(word_r);
`ifdef HUB75_BANK_EN
        if ((row_r == {ROW_BITS{1'b0}}) && (word_r == {WORD_BITS{1'b0}})) begin
            bank_next_s = bank_sel;
        end else begin
            bank_next_s = bank_r;
        end
        fetch_addr_s  = {bank_next_s, lin_addr_s[6:0]};
        unused_data_s = ^{BRAM_data[63:48], lin_addr_s[7]};
`else
        fetch_addr_s  = lin_addr_s;
        unused_data_s = ^BRAM_data[63:48];
`endif
    end

    // Column 0 comes straight from the BRAM output, which is valid only in that cycle
    always_comb begin
        if (col_r == 3'd0) begin
            shift_src_s = BRAM_data[47:0];
        end else begin
            shift_src_s = shift_r;
        end
    end

    // Scan FSM; outputs are registered and describe the cycle after each state's edge
    always_ff @(posedge HUB_clk) begin
        if (HUB_rst) begin
            state_r   <= ST_FETCH;
            row_r     <= {ROW_BITS{1'b0}};
            word_r    <= {WORD_BITS{1'b0}};
            col_r     <= 3'd0;
            shift_r   <= 48'd0;
            on_cnt_r  <= 16'd0;
            BRAM_en   <= 1'b0;
            BRAM_addr <= 8'd0;
            PNL_r1    <= 1'b0;
            PNL_g1    <= 1'b0;
            PNL_b1    <= 1'b0;
            PNL_r2    <= 1'b0;
            PNL_g2    <= 1'b0;
            PNL_b2    <= 1'b0;
            PNL_sclk  <= 1'b0;
            PNL_lat   <= 1'b0;
            PNL_oe_n  <= 1'b1;
            PNL_addr  <= {ROW_BITS{1'b0}};
            FRM_done  <= 1'b0;
`ifdef HUB75_BANK_EN
            bank_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_FETCH: begin
                    BRAM_en   <= 1'b1;
                    BRAM_addr <= fetch_addr_s;
                    PNL_oe_n  <= 1'b1;
                    PNL_lat   <= 1'b0;
                    PNL_sclk  <= 1'b0;
                    FRM_done  <= 1'b0;
                    col_r     <= 3'd0;
`ifdef HUB75_BANK_EN
                    bank_r    <= bank_next_s;
`endif
                    state_r   <= ST_LOAD;
                end
                ST_LOAD: begin
                    BRAM_en <= 1'b0;
                    state_r <= ST_SHIFT_LO;
                end
                ST_SHIFT_LO: begin
                    PNL_r1   <= shift_src_s[0];
                    PNL_g1   <= shift_src_s[1];
                    PNL_b1   <= shift_src_s[2];
                    PNL_r2   <= shift_src_s[3];
                    PNL_g2   <= shift_src_s[4];
                    PNL_b2   <= shift_src_s[5];
                    shift_r  <= {6'd0, shift_src_s[47:6]};
                    PNL_sclk <= 1'b0;
                    state_r  <= ST_SHIFT_HI;
                end
                ST_SHIFT_HI: begin
                    PNL_sclk <= 1'b1;
                    col_r    <= col_r + 3'd1;
                    if (col_r == 3'd7) begin
                        if (word_r == LAST_WORD) begin
                            word_r  <= {WORD_BITS{1'b0}};
                            state_r <= ST_LATCH;
                        end else begin
                            word_r  <= word_r + {{(WORD_BITS-1){1'b0}}, 1'b1};
                            state_r <= ST_FETCH;
                        end
                    end else begin
                        state_r <= ST_SHIFT_LO;
                    end
                end
                ST_LATCH: begin
                    PNL_sclk <= 1'b0;
                    PNL_lat  <= 1'b1;
                    PNL_addr <= row_r;
                    on_cnt_r <= 16'd0;
                    state_r  <= ST_DISPLAY;
                end
                ST_DISPLAY: begin
                    PNL_lat  <= 1'b0;
                    PNL_oe_n <= 1'b0;
                    if (on_cnt_r == (ON_CYCLES - 16'd1)) begin
                        on_cnt_r <= 16'd0;
                        FRM_done <= (row_r == LAST_ROW);
                        if (row_r == LAST_ROW) begin
                            row_r <= {ROW_BITS{1'b0}};
                        end else begin
                            row_r <= row_r + {{(ROW_BITS-1){1'b0}}, 1'b1};
                        end
                        state_r <= ST_FETCH;
                    end else begin
                        on_cnt_r <= on_cnt_r + 16'd1;
                        FRM_done <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_bram_scan.sv
// Randomized bench for hub75_bram_scan: a BRAM model feeds the DUT and a frame-level
// reference (addresses, column bits, latch/enable timing) is derived from the memory contents.
module tb_hub75_bram_scan;

    localparam int COLS      = 16;
    localparam int ROWS      = 2;
    localparam int ROW_BITS  = 1;
    localparam int ON        = 4;
    localparam int WPR       = COLS / 8;
    localparam int NW        = ROWS * WPR;
    localparam int ROW_CYC   = 18 * WPR + 1 + ON;
    localparam int FRAME_CYC = ROWS * ROW_CYC;

    logic                HUB_clk = 1'b0;
    logic                HUB_rst = 1'b1;
    logic [7:0]          BRAM_addr;
    logic                BRAM_en;
    logic [63:0]         BRAM_data;
    logic                PNL_r1, PNL_g1, PNL_b1, PNL_r2, PNL_g2, PNL_b2;
    logic                PNL_sclk, PNL_lat, PNL_oe_n;
    logic [ROW_BITS-1:0] PNL_addr;
    logic                FRM_done;
    logic [5:0]          col_s;
`ifdef HUB75_BANK_EN
    logic                bank_sel = 1'b0;
    logic                frame_bank;
`endif

    logic [63:0] mem [0:255];
    logic [63:0] bram_q;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          fetch_idx, last_en_cyc, col_seen, oe_run, last_frm_cyc;
    logic [47:0] cur_word;
    logic        prev_sclk, prev_lat, prev_oe_n;
    logic [5:0]  prev_col;
    logic        mon_on   = 1'b0;
    logic        rand_mem = 1'b0;

    always #5 HUB_clk = ~HUB_clk;

    always @(posedge HUB_clk) begin
        if (BRAM_en) bram_q <= mem[BRAM_addr];
    end
    assign BRAM_data = bram_q;
    assign col_s     = {PNL_b2, PNL_g2, PNL_r2, PNL_b1, PNL_g1, PNL_r1};

    hub75_bram_scan #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .ROW_BITS  (ROW_BITS),
        .ON_CYCLES (16'(ON))
    ) dut (
        .HUB_clk   (HUB_clk),
        .HUB_rst   (HUB_rst),
        .BRAM_addr (BRAM_addr),
        .BRAM_en   (BRAM_en),
        .BRAM_data (BRAM_data),
        .PNL_r1    (PNL_r1),
        .PNL_g1    (PNL_g1),
        .PNL_b1    (PNL_b1),
        .PNL_r2    (PNL_r2),
        .PNL_g2    (PNL_g2),
        .PNL_b2    (PNL_b2),
        .PNL_sclk  (PNL_sclk),
        .PNL_lat   (PNL_lat),
        .PNL_oe_n  (PNL_oe_n),
        .PNL_addr  (PNL_addr),
        .FRM_done  (FRM_done)
`ifdef HUB75_BANK_EN
        ,
        .bank_sel  (bank_sel)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    endtask

    task automatic model_reset();
        fetch_idx    = 0;
        last_en_cyc  = -1;
        col_seen     = 0;
        oe_run       = 0;
        last_frm_cyc = -1;
        prev_sclk    = 1'b0;
        prev_lat     = 1'b0;
        prev_oe_n    = 1'b1;
        prev_col     = 6'd0;
    endtask

    task automatic monitor();
        logic [7:0] exp_addr;
        int         exp_row;
        if (BRAM_en) begin
            exp_addr = 8'(fetch_idx % NW);
`ifdef HUB75_BANK_EN
            if (fetch_idx % NW == 0) frame_bank = bank_sel;
            exp_addr[7] = frame_bank;
`endif
            check_val("fetch_addr", 64'(BRAM_addr), 64'(exp_addr));
            if (last_en_cyc >= 0) begin
                check_val("fetch_gap", 64'(cyc - last_en_cyc),
                          64'((fetch_idx % WPR == 0) ? (18 + 1 + ON) : 18));
                check_val("rises_per_word", 64'(col_seen), 64'(8));
            end
            cur_word    = mem[BRAM_addr][47:0];
            col_seen    = 0;
            last_en_cyc = cyc;
            fetch_idx++;
        end
        if (PNL_sclk && !prev_sclk) begin
            check_val("rise_in_word", 64'(col_seen < 8), 64'(1));
            if (col_seen < 8) check_val("col_data", 64'(col_s), 64'(cur_word[6*col_seen +: 6]));
            check_val("data_setup", 64'(col_s), 64'(prev_col));
            check_val("sclk_vs_lat", 64'(PNL_lat), 64'(0));
            col_seen++;
        end
        if (PNL_lat) begin
            exp_row = ((fetch_idx - 1) / WPR) % ROWS;
            check_val("lat_addr", 64'(PNL_addr), 64'(exp_row));
            check_val("lat_width", 64'(prev_lat), 64'(0));
            check_val("lat_sclk", 64'(PNL_sclk), 64'(0));
            check_val("lat_row_done", 64'(col_seen), 64'(8));
        end
        if (!PNL_oe_n) begin
            if (prev_oe_n) check_val("oe_after_lat", 64'(prev_lat), 64'(1));
            oe_run++;
        end else if (!prev_oe_n) begin
            check_val("oe_width", 64'(oe_run), 64'(ON));
            oe_run = 0;
        end
        if (FRM_done) begin
            check_val("frm_row", 64'(PNL_addr), 64'(ROWS - 1));
            check_val("frm_last_on", 64'(oe_run), 64'(ON));
            if (last_frm_cyc >= 0) check_val("frm_period", 64'(cyc - last_frm_cyc), 64'(FRAME_CYC));
            last_frm_cyc = cyc;
            if (rand_mem) randomize_mem();
        end
        prev_sclk = PNL_sclk;
        prev_lat  = PNL_lat;
        prev_oe_n = PNL_oe_n;
        prev_col  = col_s;
    endtask

    task automatic step();
        @(negedge HUB_clk);
        cyc++;
        if (mon_on) monitor();
    endtask

    task automatic reset_seq(input int n);
        mon_on  = 1'b0;
        HUB_rst = 1'b1;
        repeat (n) step();
        check_val("rst_oe_n", 64'(PNL_oe_n), 64'(1));
        check_val("rst_sclk", 64'(PNL_sclk), 64'(0));
        check_val("rst_lat", 64'(PNL_lat), 64'(0));
        check_val("rst_pnl_addr", 64'(PNL_addr), 64'(0));
        check_val("rst_en", 64'(BRAM_en), 64'(0));
        check_val("rst_bram_addr", 64'(BRAM_addr), 64'(0));
        check_val("rst_frm", 64'(FRM_done), 64'(0));
        HUB_rst = 1'b0;
        model_reset();
        mon_on = 1'b1;
        step();
        check_val("first_fetch_en", 64'(BRAM_en), 64'(1));
    endtask

    task automatic wait_frames(input int n);
        int got;
        got = 0;
        for (int i = 0; (i < n * FRAME_CYC + 2 * ROW_CYC) && (got < n); i++) begin
            step();
            if (FRM_done) got++;
`ifdef HUB75_BANK_EN
            if (rand_mem && BRAM_en && (fetch_idx % NW == 1)) bank_sel = 1'($urandom);
`endif
        end
        check_val("frames_done", 64'(got), 64'(n));
    endtask

    initial begin
        randomize_mem();
        mem[0] = 64'h0000_0000_0000_003F;
        mem[1] = 64'h0000_FC00_0000_0000;
        model_reset();
        reset_seq(3);
        wait_frames(2);

        // reset in the middle of row 1's shift phase
        for (int i = 0; i < FRAME_CYC; i++) begin
            step();
            if (BRAM_en && (fetch_idx % NW == WPR + 1)) break;
        end
        repeat (6) step();
        check_val("mid_shift_lat", 64'(PNL_lat), 64'(0));
        reset_seq(1);
        wait_frames(1);

        rand_mem = 1'b1;
`ifdef HUB75_BANK_EN
        bank_sel = 1'b1;
`endif
        wait_frames(3);
        repeat (4) begin
            repeat ($urandom_range(5, FRAME_CYC)) step();
            reset_seq(1);
            wait_frames(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
